// File: rtl/rv_mem.sv
// rv_mem: memory-access stage of the rv pipeline (Q103H -> Q104H).
//
// Issues loads and stores to the data memory over a req/gnt/rvalid handshake,
// stalls Q103H while a transaction is outstanding, formats load data by byte
// lane, size and sign, and registers the Q103H->Q104H pipeline boundary.
//
// Ports
//   clk, rst                      clock (rising edge), async active-low reset
//   *_Q103H inputs                instruction fields from execute
//   dmem_req/we/addr/be/wr_data   request to data memory
//   dmem_gnt/rvalid/rdata         grant and read response from data memory
//   stall_Q103H                   hold Q103H and everything upstream
//   misaligned_Q103H              misaligned access trap (combinational)
//   *_Q104H outputs               registered pipeline boundary into writeback
//   dbg_state                     FSM state: 0 IDLE, 1 WAIT_GNT, 2 WAIT_RSP
//
// Handshake: a request is presented while dmem_req=1 and is accepted in the
// cycle dmem_gnt=1; address, we, be and wr_data stay stable until then. A
// load's data is taken in the cycle dmem_rvalid=1 while waiting for it; an
// rvalid arriving at any other time is ignored. Only one transaction is ever
// outstanding.
module rv_mem (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_Q103H,
  input  logic        is_load_Q103H,
  input  logic        is_store_Q103H,
  input  logic [1:0]  size_Q103H,
  input  logic        unsigned_Q103H,
  input  logic [31:0] addr_Q103H,
  input  logic [31:0] st_data_Q103H,
  input  logic [31:0] pre_wb_data_Q103H,
  input  logic [4:0]  rd_Q103H,
  input  logic        rd_wr_en_Q103H,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wr_data,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        stall_Q103H,
  output logic        misaligned_Q103H,
  output logic        valid_Q104H,
  output logic [31:0] pre_wb_data_Q104H,
  output logic [31:0] dmem_rd_data_Q104H,
  output logic [4:0]  rd_Q104H,
  output logic        rd_wr_en_Q104H,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_GNT = 2'd1,
    WAIT_RSP = 2'd2
  } state_t;

  state_t      state;
  logic        mem_op;
  logic        op_store;
  logic        aligned_op;
  logic        load_done;
  logic [1:0]  ofs;
  logic [31:0] shifted;
  logic [31:0] ld_fmt;

  assign ofs      = addr_Q103H[1:0];
  assign mem_op   = valid_Q103H & (is_load_Q103H | is_store_Q103H);
  // A memory op that is not a store is handled as a load.
  assign op_store = is_store_Q103H;

  // Size 11 is reserved and behaves as a word access (size[1] set).
  assign misaligned_Q103H = mem_op &
                            (((size_Q103H == 2'b01) & ofs[0]) |
                             (size_Q103H[1] & (ofs != 2'b00)));
  assign aligned_op = mem_op & ~misaligned_Q103H;

  assign load_done = (state == WAIT_RSP) & dmem_rvalid;
  assign dbg_state = state;

  // Request and stall are combinational so a store with same-cycle grant
  // costs no stall. Reset forces the request low even with an op present.
  always_comb begin
    dmem_req    = 1'b0;
    stall_Q103H = 1'b0;
    case (state)
      IDLE: begin
        dmem_req    = aligned_op & rst;
        stall_Q103H = aligned_op & (~dmem_gnt | ~op_store);
      end
      WAIT_GNT: begin
        dmem_req    = 1'b1;
        stall_Q103H = ~dmem_gnt | ~op_store;
      end
      WAIT_RSP: begin
        stall_Q103H = ~dmem_rvalid;
      end
      default: begin
        dmem_req    = 1'b0;
        stall_Q103H = 1'b0;
      end
    endcase
  end

  assign dmem_we   = mem_op & op_store;
  assign dmem_addr = {addr_Q103H[31:2], 2'b00};

  // Store data is replicated across lanes so the memory only needs the
  // byte enables to place it.
  always_comb begin
    dmem_be      = 4'hF;
    dmem_wr_data = st_data_Q103H;
    if (op_store) begin
      case (size_Q103H)
        2'b00: begin
          dmem_be      = 4'b0001 << ofs;
          dmem_wr_data = {4{st_data_Q103H[7:0]}};
        end
        2'b01: begin
          dmem_be      = 4'b0011 << ofs;
          dmem_wr_data = {2{st_data_Q103H[15:0]}};
        end
        default: begin
          dmem_be      = 4'hF;
          dmem_wr_data = st_data_Q103H;
        end
      endcase
    end
  end

  // Load formatting uses the Q103H fields, which are held stable while the
  // load is outstanding.
  assign shifted = dmem_rdata >> {ofs, 3'b000};

  always_comb begin
    case (size_Q103H)
      2'b00:   ld_fmt = {{24{~unsigned_Q103H & shifted[7]}},  shifted[7:0]};
      2'b01:   ld_fmt = {{16{~unsigned_Q103H & shifted[15]}}, shifted[15:0]};
      default: ld_fmt = shifted;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state              <= IDLE;
      valid_Q104H        <= 1'b0;
      pre_wb_data_Q104H  <= 32'h0;
      dmem_rd_data_Q104H <= 32'h0;
      rd_Q104H           <= 5'h0;
      rd_wr_en_Q104H     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (aligned_op) begin
            if (!dmem_gnt)     state <= WAIT_GNT;
            else if (op_store) state <= IDLE;
            else               state <= WAIT_RSP;
          end
        end
        WAIT_GNT: begin
          if (dmem_gnt) state <= op_store ? IDLE : WAIT_RSP;
        end
        WAIT_RSP: begin
          if (dmem_rvalid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // A stalled cycle sends a bubble; the data fields are left as they were.
      if (stall_Q103H) begin
        valid_Q104H    <= 1'b0;
        rd_wr_en_Q104H <= 1'b0;
      end else begin
        valid_Q104H        <= valid_Q103H & ~misaligned_Q103H;
        pre_wb_data_Q104H  <= pre_wb_data_Q103H;
        rd_Q104H           <= rd_Q103H;
        rd_wr_en_Q104H     <= rd_wr_en_Q103H & valid_Q103H & ~misaligned_Q103H;
        dmem_rd_data_Q104H <= load_done ? ld_fmt : 32'h0;
      end
    end
  end

endmodule
